// File: rtl/countdown_run_ctrl_if.sv
// Command/status bundle between the countdown controller and its neighbours.
// The master side (time-set service, button logic, display) drives commands.
// The slave side (countdown_run_ctrl) returns the registered status.
interface countdown_run_ctrl_if;
    logic        load;
    logic [15:0] load_time;
    logic        start_stop;
    logic        clear;
    logic [15:0] time_out;
    logic [1:0]  state;
    logic        alarm;
    logic        done;
    logic        load_err;
    logic [3:0]  blank;

    modport master (
        output load, load_time, start_stop, clear,
        input  time_out, state, alarm, done, load_err, blank
    );

    modport slave (
        input  load, load_time, start_stop, clear,
        output time_out, state, alarm, done, load_err, blank
    );
endinterface

// File: rtl/countdown_run_ctrl.sv
// MM:SS countdown sequencer. It takes a BCD time from the time-set service and
// counts it down once per CLK_HZ clocks. It handles start/pause/resume, clear,
// and an alarm phase that lasts ALARM_SEC seconds.
// Optional build macro ALARM_BLINK_EN: the display blank mask blinks at 1 Hz
// while in ALARM. Without the macro, blank is tied to 0000.
module countdown_run_ctrl #(
    parameter int CLK_HZ    = 100000000,
    parameter int ALARM_SEC = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    countdown_run_ctrl_if.slave  bus
);
    localparam int              DIV_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t           st, st_nx;
    logic [DIV_W-1:0] div, div_nx, div_inc;
    logic [3:0]       asec, asec_nx;
    logic [15:0]      tm, tm_nx;
    logic             alarm_q, alarm_nx;
    logic             done_q, done_nx;
    logic             lerr_q, lerr_nx;
    logic             tick;

    // MM:SS digit ranges: tens digits 0..5, units digits 0..9.
    function automatic logic bcd_ok(input logic [15:0] v);
        return (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) &&
               (v[7:4]   <= 4'd5) && (v[3:0]  <= 4'd9);
    endfunction

    // One-second BCD decrement. A borrow ripples from the seconds units digit upward.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign tick    = ((st == RUN) || (st == ALARM)) && (div == DIV_MAX);
    assign div_inc = tick ? '0 : div + 1'b1;

    // Next-state and next-output logic. Priority order: clear, then load, then start_stop, then tick.
    always_comb begin
        st_nx    = st;
        tm_nx    = tm;
        div_nx   = div;
        asec_nx  = asec;
        alarm_nx = alarm_q;
        done_nx  = 1'b0;
        lerr_nx  = 1'b0;

        if (bus.clear) begin
            st_nx    = IDLE;
            tm_nx    = 16'h0000;
            div_nx   = '0;
            alarm_nx = 1'b0;
        end else if (bus.load) begin
            if (bcd_ok(bus.load_time)) begin
                st_nx    = IDLE;
                tm_nx    = bus.load_time;
                div_nx   = '0;
                alarm_nx = 1'b0;
            end else begin
                // A rejected load freezes the whole cycle, including the divider.
                // This keeps the running second from being skipped.
                lerr_nx = 1'b1;
            end
        end else begin
            case (st)
                IDLE: begin
                    div_nx = '0;
                    if (bus.start_stop && (tm != 16'h0000)) st_nx = RUN;
                end
                RUN: begin
                    div_nx = div_inc;
                    if (bus.start_stop) begin
                        st_nx = PAUSE;
                        // A tick swallowed by the pause stays pending.
                        // It then fires on the first clock after resume.
                        if (tick) div_nx = div;
                    end else if (tick) begin
                        if (tm == 16'h0001) begin
                            tm_nx    = 16'h0000;
                            st_nx    = ALARM;
                            alarm_nx = 1'b1;
                            done_nx  = 1'b1;
                            div_nx   = '0;
                            asec_nx  = 4'd0;
                        end else begin
                            tm_nx = bcd_dec(tm);
                        end
                    end
                end
                PAUSE: begin
                    if (bus.start_stop) st_nx = RUN;
                end
                ALARM: begin
                    div_nx = div_inc;
                    if (bus.start_stop) begin
                        st_nx    = IDLE;
                        alarm_nx = 1'b0;
                        div_nx   = '0;
                    end else if (tick) begin
                        asec_nx = asec + 4'd1;
                        if (asec_nx == 4'(ALARM_SEC)) begin
                            st_nx    = IDLE;
                            alarm_nx = 1'b0;
                            div_nx   = '0;
                        end
                    end
                end
                default: st_nx = IDLE;
            endcase
        end
    end

    // State and output registers. Reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= IDLE;
            tm      <= 16'h0000;
            div     <= '0;
            asec    <= 4'd0;
            alarm_q <= 1'b0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            st      <= st_nx;
            tm      <= tm_nx;
            div     <= div_nx;
            asec    <= asec_nx;
            alarm_q <= alarm_nx;
            done_q  <= done_nx;
            lerr_q  <= lerr_nx;
        end
    end

`ifdef ALARM_BLINK_EN
    localparam int             HALF = (CLK_HZ / 2 > 1) ? CLK_HZ / 2 : 1;
    localparam int             HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0]  HMAX = HW'(HALF - 1);
    logic [HW-1:0] hc;
    logic [3:0]    blank_q;

    // Half-second blinker. The mask is all-blank on ALARM entry and clears as soon as ALARM is left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc      <= '0;
            blank_q <= 4'h0;
        end else if (st_nx != ALARM) begin
            hc      <= '0;
            blank_q <= 4'h0;
        end else if (st != ALARM) begin
            hc      <= '0;
            blank_q <= 4'hF;
        end else if (hc == HMAX) begin
            hc      <= '0;
            blank_q <= ~blank_q;
        end else begin
            hc      <= hc + 1'b1;
        end
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = 4'h0;
`endif

    assign bus.time_out = tm;
    assign bus.state    = st;
    assign bus.alarm    = alarm_q;
    assign bus.done     = done_q;
    assign bus.load_err = lerr_q;
endmodule

// File: tb/tb_countdown_run_ctrl.sv
// Directed bench for countdown_run_ctrl with CLK_HZ=10 and ALARM_SEC=3.
// Inputs change 1 ns after each rising edge, and outputs are checked at that
// same point. A wait of N cycles therefore looks at the result of N edges.
module tb_countdown_run_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errs    = 0;

`ifdef ALARM_BLINK_EN
    localparam logic [3:0] BLINK_ON = 4'hF;
`else
    localparam logic [3:0] BLINK_ON = 4'h0;
`endif

    countdown_run_ctrl_if bif();

    countdown_run_ctrl #(.CLK_HZ(10), .ALARM_SEC(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        bif.load      = 1'b1;
        bif.load_time = v;
        cyc(1);
        bif.load      = 1'b0;
    endtask

    task automatic do_ss();
        bif.start_stop = 1'b1;
        cyc(1);
        bif.start_stop = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bif.load       = 1'b0;
        bif.load_time  = 16'h0000;
        bif.start_stop = 1'b0;
        bif.clear      = 1'b0;
        cyc(2);
        chk("rst_time",  bif.time_out, 16'h0000);
        chk("rst_state", 16'(bif.state), 16'd0);
        chk("rst_alarm", 16'(bif.alarm), 16'd0);
        chk("rst_done",  16'(bif.done), 16'd0);
        chk("rst_lerr",  16'(bif.load_err), 16'd0);
        chk("rst_blank", 16'(bif.blank), 16'd0);
        reset = 1'b0;
        cyc(1);

        // 1: 00:12 counts down, borrowing into the seconds-tens digit
        do_load(16'h0012);
        chk("t1_load", bif.time_out, 16'h0012);
        do_ss();
        chk("t1_run", 16'(bif.state), 16'd1);
        cyc(9);
        chk("t1_pre_tick", bif.time_out, 16'h0012);
        cyc(1);
        chk("t1_10", bif.time_out, 16'h0011);
        cyc(10);
        chk("t1_20", bif.time_out, 16'h0010);
        cyc(10);
        chk("t1_30_borrow", bif.time_out, 16'h0009);
        chk("t1_state", 16'(bif.state), 16'd1);

        // 2: borrow across the minutes digits
        do_load(16'h0100);
        chk("t2_load_idle", 16'(bif.state), 16'd0);
        do_ss();
        cyc(10);
        chk("t2_0059", bif.time_out, 16'h0059);
        do_load(16'h1000);
        do_ss();
        cyc(10);
        chk("t2_0959", bif.time_out, 16'h0959);

        // 3: reach zero, then the alarm phase and its timed return to IDLE
        do_load(16'h0002);
        do_ss();
        cyc(19);
        chk("t3_pre_done", 16'(bif.done), 16'd0);
        chk("t3_0001", bif.time_out, 16'h0001);
        cyc(1);
        chk("t3_done", 16'(bif.done), 16'd1);
        chk("t3_zero", bif.time_out, 16'h0000);
        chk("t3_alarm_st", 16'(bif.state), 16'd3);
        chk("t3_alarm", 16'(bif.alarm), 16'd1);
        chk("t3_blank_entry", 16'(bif.blank), 16'(BLINK_ON));
        cyc(1);
        chk("t3_done_once", 16'(bif.done), 16'd0);
        cyc(3);
        chk("t3_blank_a4", 16'(bif.blank), 16'(BLINK_ON));
        cyc(1);
        chk("t3_blank_a5", 16'(bif.blank), 16'd0);
        cyc(5);
        chk("t3_blank_a10", 16'(bif.blank), 16'(BLINK_ON));
        cyc(19);
        chk("t3_still_alarm", 16'(bif.state), 16'd3);
        cyc(1);
        chk("t3_idle", 16'(bif.state), 16'd0);
        chk("t3_alarm_off", 16'(bif.alarm), 16'd0);
        chk("t3_blank_off", 16'(bif.blank), 16'd0);

        // 4: pause mid-second; after resume only the rest of that second is waited out
        do_load(16'h0030);
        do_ss();
        cyc(10);
        chk("t4_0029", bif.time_out, 16'h0029);
        cyc(3);
        do_ss();
        chk("t4_pause", 16'(bif.state), 16'd2);
        cyc(50);
        chk("t4_hold_st", 16'(bif.state), 16'd2);
        chk("t4_hold_tm", bif.time_out, 16'h0029);
        do_ss();
        chk("t4_resume", 16'(bif.state), 16'd1);
        cyc(5);
        chk("t4_r5", bif.time_out, 16'h0029);
        cyc(1);
        chk("t4_r6", bif.time_out, 16'h0028);

        // 5: rejected loads, and start_stop at 00:00
        do_load(16'h0A00);
        chk("t5_lerr", 16'(bif.load_err), 16'd1);
        chk("t5_tm_kept", bif.time_out, 16'h0028);
        chk("t5_st_kept", 16'(bif.state), 16'd1);
        cyc(1);
        chk("t5_lerr_once", 16'(bif.load_err), 16'd0);
        do_load(16'h0060);
        chk("t5_lerr_sec", 16'(bif.load_err), 16'd1);
        bif.clear = 1'b1;
        cyc(1);
        bif.clear = 1'b0;
        chk("t5_clear_tm", bif.time_out, 16'h0000);
        do_ss();
        chk("t5_zero_ss", 16'(bif.state), 16'd0);

        // 6: clear beats load; a pause that lands on a tick; async reset
        do_load(16'h0500);
        do_ss();
        cyc(3);
        bif.clear     = 1'b1;
        bif.load      = 1'b1;
        bif.load_time = 16'h0123;
        cyc(1);
        bif.clear     = 1'b0;
        bif.load      = 1'b0;
        chk("t6_clr_tm", bif.time_out, 16'h0000);
        chk("t6_clr_st", 16'(bif.state), 16'd0);
        do_load(16'h0040);
        do_ss();
        cyc(9);
        do_ss();
        chk("t6_tick_pause_st", 16'(bif.state), 16'd2);
        chk("t6_tick_pause_tm", bif.time_out, 16'h0040);
        do_ss();
        cyc(1);
        chk("t6_pending_tick", bif.time_out, 16'h0039);
        cyc(3);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_tm", bif.time_out, 16'h0000);
        chk("t6_rst_st", 16'(bif.state), 16'd0);
        chk("t6_rst_alarm", 16'(bif.alarm), 16'd0);
        cyc(1);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
